// File: rtl/icache_pkg.sv
// Shared icache types: line/word geometry defaults and the line-fill FSM states.
// Imported by the line server and by the icache itself.
package icache_pkg;

    localparam int DEF_LINE_SIZE = 4;
    localparam int DEF_WORD_SIZE = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        SEND = 2'd2
    } line_state_t;

endpackage

// File: rtl/imem_line_server_if.sv
// Line-fill bus between the icache (master) and the imem line server (slave).
// Carries the request channel, the response beat channel and the preload write port.
interface imem_line_server_if
    import icache_pkg::*;
#(
    parameter int WORD_SIZE = DEF_WORD_SIZE
) ();

    logic                 req_valid;
    logic                 req_ready;
    logic [31:0]          req_addr;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [WORD_SIZE-1:0] resp_data;
    logic                 resp_last;
    logic                 wr_en;
    logic [31:0]          wr_addr;
    logic [WORD_SIZE-1:0] wr_data;

    modport master (
        output req_valid, req_addr, resp_ready,
        output wr_en, wr_addr, wr_data,
        input  req_ready, resp_valid, resp_data, resp_last
    );

    modport slave (
        input  req_valid, req_addr, resp_ready,
        input  wr_en, wr_addr, wr_data,
        output req_ready, resp_valid, resp_data, resp_last
    );

endinterface

// File: rtl/imem_array.sv
// Backing store for the line server: one synchronous write port, one async read port.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (combinational read). No reset.
module imem_array #(
    parameter int WORD_SIZE = 32,
    parameter int DEPTH     = 1024,
    localparam int IDX_W    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [IDX_W-1:0]     waddr,
    input  logic [WORD_SIZE-1:0] wdata,
    input  logic [IDX_W-1:0]     raddr,
    output logic [WORD_SIZE-1:0] rdata
);

    logic [WORD_SIZE-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/imem_line_server.sv
// Instruction-memory line server: accepts a line-fill request, waits LATENCY cycles,
// then streams LINE_SIZE words from the line base. Ports: clk, reset, bus (slave).
module imem_line_server
    import icache_pkg::*;
#(
    parameter int LINE_SIZE = DEF_LINE_SIZE,
    parameter int WORD_SIZE = DEF_WORD_SIZE,
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 4
) (
    input  logic               clk,
    input  logic               reset,
    imem_line_server_if.slave  bus
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int OFF_W = $clog2(LINE_SIZE);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [CNT_W-1:0] LAT_LOAD  = CNT_W'(LATENCY - 1);
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_SIZE - 1);

    line_state_t          state_q, state_d;
    logic [IDX_W-1:0]     base_q, base_d;
    logic [OFF_W-1:0]     beat_q, beat_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic [IDX_W-1:0]     rd_idx;
    logic [IDX_W-1:0]     wr_idx;
    logic [WORD_SIZE-1:0] rd_data;

    // Byte-address bits outside the word index are deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.req_addr[31:IDX_W+2],
                                bus.req_addr[OFF_W+1:0],
                                bus.wr_addr[31:IDX_W+2],
                                bus.wr_addr[1:0]};

    // IDX_W-bit add wraps the line modulo MEM_WORDS.
    assign rd_idx = base_q + IDX_W'(beat_q);
    assign wr_idx = bus.wr_addr[IDX_W+1:2];

    imem_array #(
        .WORD_SIZE (WORD_SIZE),
        .DEPTH     (MEM_WORDS)
    ) u_array (
        .clk   (clk),
        .we    (bus.wr_en),
        .waddr (wr_idx),
        .wdata (bus.wr_data),
        .raddr (rd_idx),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            base_q  <= '0;
            beat_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            beat_q  <= beat_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        beat_d  = beat_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    base_d  = {bus.req_addr[IDX_W+1:OFF_W+2], {OFF_W{1'b0}}};
                    cnt_d   = LAT_LOAD;
                    beat_d  = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = SEND;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            SEND: begin
                if (bus.resp_ready) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = IDLE;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode straight from state so an async reset clears them at once.
    always_comb begin
        bus.req_ready  = (state_q == IDLE);
        bus.resp_valid = (state_q == SEND);
        bus.resp_last  = (state_q == SEND) && (beat_q == LAST_BEAT);
        bus.resp_data  = (state_q == SEND) ? rd_data : '0;
    end

endmodule

// File: tb/tb_imem_line_server.sv
// Self-checking bench for imem_line_server: table-driven bursts with a beat
// scoreboard, plus hand-written reset-abort sequence.
module tb_imem_line_server;

    localparam int LINE = 4;
    localparam int WS   = 32;
    localparam int MW   = 1024;
    localparam int LAT  = 4;

    typedef struct {
        logic [31:0]           addr;
        int                    stall_beat;
        int                    stall_len;
        bit                    hold;
        bit                    do_wr;
        logic [3:0][31:0]      exp;
    } vec_t;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_miss;
    int   n_acc;
    logic [31:0] exp_q[$];
    vec_t vecs[7];

    imem_line_server_if #(.WORD_SIZE(WS)) bus ();

    imem_line_server #(
        .LINE_SIZE (LINE),
        .WORD_SIZE (WS),
        .MEM_WORDS (MW),
        .LATENCY   (LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset && bus.req_valid && bus.req_ready) begin
            n_acc++;
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input int idx, input logic [31:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 32'(idx) << 2;
        bus.wr_data = data;
        step();
        bus.wr_en   = 1'b0;
    endtask

    task automatic check_beat(input string name, input bit last, input bit pop);
        logic [31:0] want;
        check({name, "_valid"}, 32'(bus.resp_valid), 32'd1);
        check({name, "_last"}, 32'(bus.resp_last), 32'(last));
        check({name, "_rdy_busy"}, 32'(bus.req_ready), 32'd0);
        if (exp_q.size() == 0) begin
            check({name, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            want = pop ? exp_q.pop_front() : exp_q[0];
            check({name, "_data"}, bus.resp_data, want);
        end
    endtask

    task automatic do_burst(input vec_t v);
        int k;
        int acc0;
        k = 0;
        while (!bus.req_ready && k < 20) begin
            step();
            k++;
        end
        check("req_ready_idle", 32'(bus.req_ready), 32'd1);
        acc0 = n_acc;
        bus.req_valid = 1'b1;
        bus.req_addr  = v.addr;
        for (int b = 0; b < LINE; b++) begin
            exp_q.push_back(v.exp[b]);
        end
        step();
        if (!v.hold) bus.req_valid = 1'b0;
        k = 0;
        while (!bus.resp_valid && k < 20) begin
            check("wait_rdy_busy", 32'(bus.req_ready), 32'd0);
            check("wait_data_zero", bus.resp_data, 32'd0);
            step();
            k++;
        end
        check("first_beat_latency", 32'(k), 32'(LAT));
        for (int b = 0; b < LINE; b++) begin
            if (b == v.stall_beat) begin
                bus.resp_ready = 1'b0;
                for (int s = 0; s < v.stall_len; s++) begin
                    check_beat("stall", b == LINE - 1, 1'b0);
                    if (v.do_wr && s == 0) begin
                        bus.wr_en   = 1'b1;
                        bus.wr_addr = 32'h0000_000C;
                        bus.wr_data = 32'h0000_DEAD;
                    end
                    step();
                    bus.wr_en = 1'b0;
                end
                bus.resp_ready = 1'b1;
            end
            check_beat("beat", b == LINE - 1, 1'b1);
            step();
        end
        check("req_ready_after", 32'(bus.req_ready), 32'd1);
        check("resp_valid_after", 32'(bus.resp_valid), 32'd0);
        bus.req_valid = 1'b0;
        check("accepts_per_burst", 32'(n_acc - acc0), 32'd1);
    endtask

    initial begin
        vecs[0] = '{addr: 32'h0000_000C, stall_beat: -1, stall_len: 0,
                    hold: 0, do_wr: 0,
                    exp: {32'hA3, 32'hA2, 32'hA1, 32'hA0}};
        vecs[1] = '{addr: 32'h0000_0014, stall_beat: 1, stall_len: 3,
                    hold: 0, do_wr: 0,
                    exp: {32'hA7, 32'hA6, 32'hA5, 32'hA4}};
        vecs[2] = '{addr: 32'h0000_0FF0, stall_beat: -1, stall_len: 0,
                    hold: 0, do_wr: 0,
                    exp: {32'hF000_03FF, 32'hF000_03FE,
                          32'hF000_03FD, 32'hF000_03FC}};
        vecs[3] = '{addr: 32'h0000_1000, stall_beat: -1, stall_len: 0,
                    hold: 0, do_wr: 0,
                    exp: {32'hA3, 32'hA2, 32'hA1, 32'hA0}};
        vecs[4] = '{addr: 32'h8000_001C, stall_beat: 2, stall_len: 1,
                    hold: 0, do_wr: 0,
                    exp: {32'hA7, 32'hA6, 32'hA5, 32'hA4}};
        vecs[5] = '{addr: 32'h0000_0008, stall_beat: -1, stall_len: 0,
                    hold: 1, do_wr: 0,
                    exp: {32'hA3, 32'hA2, 32'hA1, 32'hA0}};
        vecs[6] = '{addr: 32'h0000_0000, stall_beat: 1, stall_len: 3,
                    hold: 0, do_wr: 1,
                    exp: {32'h0000_DEAD, 32'hA2, 32'hA1, 32'hA0}};

        n_vec = 0;
        n_miss = 0;
        n_acc = 0;
        reset = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_addr   = '0;
        bus.resp_ready = 1'b1;
        bus.wr_en      = 1'b0;
        bus.wr_addr    = '0;
        bus.wr_data    = '0;
        step();
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_last", 32'(bus.resp_last), 32'd0);
        check("rst_resp_data", bus.resp_data, 32'd0);
        step();
        reset = 1'b0;
        step();

        for (int i = 0; i < 8; i++) write_word(i, 32'hA0 + 32'(i));
        for (int i = 0; i < 4; i++) write_word(1020 + i, 32'hF000_03FC + 32'(i));

        for (int i = 0; i < 7; i++) begin
            do_burst(vecs[i]);
        end
        write_word(3, 32'hA3);

        // Reset lands while beat 2 of line 0 is on the bus.
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0;
        step();
        bus.req_valid = 1'b0;
        for (int k = 0; k < 20 && !bus.resp_valid; k++) step();
        check("rb_beat0", bus.resp_data, 32'hA0);
        step();
        check("rb_beat1", bus.resp_data, 32'hA1);
        step();
        check("rb_beat2", bus.resp_data, 32'hA2);
        reset = 1'b1;
        #1;
        check("rb_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rb_req_ready", 32'(bus.req_ready), 32'd1);
        check("rb_resp_last", 32'(bus.resp_last), 32'd0);
        check("rb_resp_data", bus.resp_data, 32'd0);
        step();
        reset = 1'b0;
        exp_q.delete();
        for (int k = 0; k < 6; k++) begin
            check("rb_no_resume", 32'(bus.resp_valid), 32'd0);
            step();
        end
        do_burst(vecs[3]);

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/imem_line_server.md
IMEM_LINE_SERVER -- requirements
Module: imem_line_server

Interface
REQ-001 The module SHALL have parameter LINE_SIZE, default 4, meaning words per cache line (power of two, at least 2).
REQ-002 The module SHALL have parameter WORD_SIZE, default 32, meaning bits per word.
REQ-003 The module SHALL have parameter MEM_WORDS, default 1024, meaning backing-store depth in words (power of two).
REQ-004 The module SHALL have parameter LATENCY, default 4, meaning cycles from request accept to first response beat (at least 1).
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The module SHALL have port reset, input, 1 bit: reset, asynchronous and active-high.
REQ-007 The module SHALL have port req_valid, input, 1 bit: the icache presents a line-fill request.
REQ-008 The module SHALL have port req_ready, output, 1 bit: the server can accept a request.
REQ-009 The module SHALL have port req_addr, input, 32 bits: the byte address of the missing instruction.
REQ-010 The module SHALL have port resp_valid, output, 1 bit: resp_data holds a valid line beat.
REQ-011 The module SHALL have port resp_ready, input, 1 bit: the icache accepts the current beat.
REQ-012 The module SHALL have port resp_data, output, WORD_SIZE bits: the current line word.
REQ-013 The module SHALL have port resp_last, output, 1 bit: the current beat is the final word of the line.
REQ-014 The module SHALL have port wr_en, input, 1 bit: backing-store preload write strobe.
REQ-015 The module SHALL have port wr_addr, input, 32 bits: preload byte address.
REQ-016 The module SHALL have port wr_data, input, WORD_SIZE bits: preload data.

Function
REQ-017 The FSM SHALL have three states: IDLE, WAIT and SEND.
REQ-018 In IDLE, req_ready SHALL be 1; in WAIT and SEND it SHALL be 0.
REQ-019 In IDLE, when req_valid=1 the module SHALL capture the line base word index (req_addr word index with its low log2(LINE_SIZE) bits cleared), load the latency counter with LATENCY-1, clear the beat counter, and go to WAIT.
REQ-020 In WAIT, the counter SHALL decrement each cycle, and the FSM SHALL go to SEND in the cycle after the counter reads 0; the first resp_valid therefore appears exactly LATENCY cycles after the accept edge.
REQ-021 In SEND, resp_valid SHALL be 1 and resp_data SHALL equal mem[(base + beat) mod MEM_WORDS], read combinationally.
REQ-022 resp_last SHALL be 1 only in SEND with beat == LINE_SIZE-1.
REQ-023 The beat SHALL advance only on resp_valid && resp_ready; while resp_ready=0, resp_data, resp_last and the beat SHALL hold.
REQ-024 On the accepted last beat, the FSM SHALL return to IDLE; a new request SHALL be acceptable the following cycle (no back-to-back accept in the same cycle).
REQ-025 Words SHALL always be returned in ascending order from the line base, never critical-word-first.
REQ-026 Word indices SHALL wrap modulo MEM_WORDS; address bits above the index range SHALL be ignored.
REQ-027 wr_en SHALL write mem[wr_addr word index mod MEM_WORDS] on any clock edge in any state; a beat presented in a later cycle SHALL show the new value.
REQ-028 Outside SEND, resp_valid, resp_last and resp_data SHALL be 0.

Reset
REQ-029 Asserting reset SHALL immediately force IDLE, req_ready=1, resp_valid=0, resp_last=0, resp_data=0 and clear both counters, including when reset arrives mid-WAIT or mid-SEND.
REQ-030 Reset SHALL NOT clear memory contents; an aborted burst SHALL NOT resume after reset.

Structure
REQ-031 LINE_SIZE and WORD_SIZE defaults and the state enum (IDLE, WAIT, SEND) SHALL live in shared package icache_pkg, which the icache also uses.
REQ-032 The storage array SHALL be a sub-module imem_array (one write port, one asynchronous read port); the FSM and counters SHALL live in imem_line_server.

Verification
REQ-033 Preload words 0..7 with 0xA0..0xA7; request 0x0000000C with resp_ready=1: the bench SHALL see first resp_valid 4 cycles after accept, then beats 0xA0,0xA1,0xA2,0xA3 on consecutive cycles, with resp_last on 0xA3.
REQ-034 Request 0x00000014 with resp_ready low for 3 cycles on beat 1: the bench SHALL see 0xA5 held stable for 3 cycles, then the burst completes, and req_ready returns 1 the cycle after the last beat.
REQ-035 Request 0x00000FF0 with MEM_WORDS=1024: the bench SHALL see words 1020..1023; with request 0x00001000 it SHALL see words 0..3 (wrap).
REQ-036 Assert reset during beat 2 of a burst: resp_valid SHALL drop immediately, FSM in IDLE, and memory still SHALL return 0xA0 on the next request to 0x0.
REQ-037 Hold req_valid high throughout a burst: exactly one request SHALL be accepted per burst, with req_ready 0 during WAIT/SEND.
REQ-038 Write 0xDEAD to word 3 while beat 1 of line 0 is stalled: beat 3 SHALL return 0xDEAD.
